// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit: one microstep per clock, Moore outputs except the branch PC_load.
// Define MIPS_CTRL_OVF_EXC_EN to divert ALU overflow on add/sub/addi into the EXC state.
module mips_control_fsm #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       ALU_zero,
    input  logic       ALU_overflow,
    output logic [5:0] Estado,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PC_load,
    output logic       IorD,
    output logic       wr,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       IR_load,
    output logic [1:0] PCSource,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALU_sel,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       A_load,
    output logic       B_load,
    output logic       MDR_load,
    output logic       ALUOut_load,
    output logic       RegReset,
    output logic       A_reset,
    output logic       B_reset,
    output logic       PC_reset,
    output logic       MDR_reset,
    output logic       ALUOut_reset,
    output logic       IR_reset,
    output logic       EPC_load
);

    typedef enum logic [5:0] {
        S_RST       = 6'd0,
        S_FETCH     = 6'd1,
        S_IR_LD     = 6'd2,
        S_DECODE    = 6'd3,
        S_MEM_ADDR  = 6'd4,
        S_MEM_RD    = 6'd5,
        S_MEM_WB    = 6'd6,
        S_MEM_WR    = 6'd7,
        S_R_EXEC    = 6'd8,
        S_R_WB      = 6'd9,
        S_BRANCH    = 6'd10,
        S_JUMP      = 6'd11,
        S_ADDI_EXEC = 6'd12,
        S_ADDI_WB   = 6'd13,
        S_EXC       = 6'd14
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_load;
        logic       iord;
        logic       wr;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_sel;
        logic       reg_write;
        logic       reg_dst;
        logic       a_load;
        logic       b_load;
        logic       mdr_load;
        logic       aluout_load;
        logic       epc_load;
        logic [6:0] resets;  // {Reg, A, B, PC, MDR, ALUOut, IR}
    } ctrl_t;

    localparam logic [3:0] WAIT_L = 4'(MEM_WAIT);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b110;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       wait_done;
    logic       branch_take;

    assign wait_done = (cnt_q == WAIT_L);

`ifndef MIPS_CTRL_OVF_EXC_EN
    logic unused_ovf;
    assign unused_ovf = ALU_overflow;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:      state_d = S_FETCH;
            S_FETCH:    if (wait_done) state_d = S_IR_LD;
            S_IR_LD:    state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:      state_d = S_R_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_ADDI_EXEC;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (wait_done) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (wait_done) state_d = S_FETCH;
`ifdef MIPS_CTRL_OVF_EXC_EN
            S_R_EXEC:   state_d = (ALU_overflow && (Funct == FN_ADD || Funct == FN_SUB))
                                  ? S_EXC : S_R_WB;
            S_ADDI_EXEC: state_d = ALU_overflow ? S_EXC : S_ADDI_WB;
`else
            S_R_EXEC:   state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
`endif
            S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB, S_EXC: state_d = S_FETCH;
            default:    state_d = S_RST;
        endcase

        // The counter restarts on every state change, so each wait state sees 0..MEM_WAIT.
        cnt_d = (state_d == state_q) ? cnt_q + 4'd1 : '0;

        // Outputs are decoded from the upcoming state so they are registered yet aligned with Estado.
        ctrl_d = '0;
        case (state_d)
            S_RST:    ctrl_d.resets = '1;
            S_IR_LD: begin
                ctrl_d.ir_write  = 1'b1;
                ctrl_d.alu_src_b = 2'b01;
                ctrl_d.alu_sel   = ALU_ADD;
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_load   = 1'b1;
            end
            S_DECODE: begin
                ctrl_d.a_load      = 1'b1;
                ctrl_d.b_load      = 1'b1;
                ctrl_d.alu_src_b   = 2'b11;
                ctrl_d.alu_sel     = ALU_ADD;
                ctrl_d.aluout_load = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl_d.alu_src_a   = 1'b1;
                ctrl_d.alu_src_b   = 2'b10;
                ctrl_d.alu_sel     = ALU_ADD;
                ctrl_d.aluout_load = 1'b1;
            end
            S_MEM_RD: begin
                ctrl_d.iord     = 1'b1;
                ctrl_d.mdr_load = (cnt_d == WAIT_L);
            end
            S_MEM_WB: begin
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_d.iord = 1'b1;
                ctrl_d.wr   = 1'b1;
            end
            S_R_EXEC: begin
                ctrl_d.alu_src_a   = 1'b1;
                ctrl_d.aluout_load = 1'b1;
                case (Funct)
                    FN_SUB:  ctrl_d.alu_sel = ALU_SUB;
                    FN_AND:  ctrl_d.alu_sel = ALU_AND;
                    FN_XOR:  ctrl_d.alu_sel = ALU_XOR;
                    default: ctrl_d.alu_sel = ALU_ADD;
                endcase
            end
            S_R_WB: begin
                ctrl_d.reg_dst   = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            S_ADDI_WB: ctrl_d.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_sel       = ALU_SUB;
                ctrl_d.pc_source     = 2'b01;
                ctrl_d.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                ctrl_d.pc_source = 2'b10;
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_load   = 1'b1;
            end
`ifdef MIPS_CTRL_OVF_EXC_EN
            S_EXC: begin
                ctrl_d.epc_load  = 1'b1;
                ctrl_d.pc_source = 2'b11;
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_load   = 1'b1;
            end
`endif
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q       <= S_RST;
            cnt_q         <= '0;
            ctrl_q        <= '0;
            ctrl_q.resets <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Branch PC_load follows the live ALU_zero flag, the only Mealy output.
    assign branch_take = (state_q == S_BRANCH) && ((Opcode == OP_BNE) ? !ALU_zero : ALU_zero);

    assign Estado       = state_q;
    assign PCWrite      = ctrl_q.pc_write;
    assign PCWriteCond  = ctrl_q.pc_write_cond;
    assign PC_load      = ctrl_q.pc_load | branch_take;
    assign IorD         = ctrl_q.iord;
    assign wr           = ctrl_q.wr;
    assign MemtoReg     = ctrl_q.mem_to_reg;
    assign IRWrite      = ctrl_q.ir_write;
    assign IR_load      = ctrl_q.ir_write;
    assign PCSource     = ctrl_q.pc_source;
    assign ALUSrcA      = ctrl_q.alu_src_a;
    assign ALUSrcB      = ctrl_q.alu_src_b;
    assign ALU_sel      = ctrl_q.alu_sel;
    assign RegWrite     = ctrl_q.reg_write;
    assign RegDst       = ctrl_q.reg_dst;
    assign A_load       = ctrl_q.a_load;
    assign B_load       = ctrl_q.b_load;
    assign MDR_load     = ctrl_q.mdr_load;
    assign ALUOut_load  = ctrl_q.aluout_load;
    assign EPC_load     = ctrl_q.epc_load;
    assign RegReset     = ctrl_q.resets[6];
    assign A_reset      = ctrl_q.resets[5];
    assign B_reset      = ctrl_q.resets[4];
    assign PC_reset     = ctrl_q.resets[3];
    assign MDR_reset    = ctrl_q.resets[2];
    assign ALUOut_reset = ctrl_q.resets[1];
    assign IR_reset     = ctrl_q.resets[0];

endmodule
